apple_spawner: RTL

//  Parametrised multi-apple placer for the snake playfield; successor to the single-apple generator.

---
 rtl/apple_spawner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apple_spawner.sv
// Multi-apple placer for the snake playfield: respawns an eaten apple on a random free cell,
// serially checking the snake body, with a linear-sweep fallback and a sticky full-board flag.
module apple_spawner #(
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned MAX_LENGTH = 16,
  parameter int unsigned NUM_APPLES = 2,
  parameter int unsigned MAX_TRIES  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              goodColl,
  input  logic [COORD_W-1:0]                head_x,
  input  logic [COORD_W-1:0]                head_y,
  input  logic [COORD_W-1:0]                rand_x,
  input  logic [COORD_W-1:0]                rand_y,
  input  logic [MAX_LENGTH*2*COORD_W-1:0]   body,
  input  logic [$clog2(MAX_LENGTH+1)-1:0]   body_len,
  input  logic [COORD_W-1:0]                x,
  input  logic [COORD_W-1:0]                y,
  output logic                              apple,
  output logic [NUM_APPLES*2*COORD_W-1:0]   apple_pos,
  output logic [NUM_APPLES-1:0]             apple_valid,
  output logic                              busy,
  output logic                              board_full
);

  localparam int unsigned PW    = 2 * COORD_W;
  localparam int unsigned LEN_W = $clog2(MAX_LENGTH + 1);
  localparam int unsigned IDX_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam int unsigned TGT_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned SWP_W = PW + 1;
  localparam logic [SWP_W-1:0] SweepAll = {1'b1, {PW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StDraw, StScan, StCommit, StFull} state_e;

  state_e                         state_q;
  logic [2:0]                     sync_q;
  logic                           pending_q;
  logic [TRY_W-1:0]               tries_q;
  logic [SWP_W-1:0]               sweep_q;
  logic [LEN_W-1:0]               idx_q;
  logic [PW-1:0]                  cand_q;
  logic [TGT_W-1:0]               target_q;
  logic [NUM_APPLES-1:0][PW-1:0]  pos_q;

  logic [MAX_LENGTH-1:0][PW-1:0]  body_arr;
  logic [LEN_W-1:0]               len_c;
  logic                           eat_evt;
  logic                           match;
  logic [TGT_W-1:0]               match_idx;
  logic                           apple_at;
  logic                           cand_apple;
  logic                           body_hit;
  logic                           hit;
  logic                           last_idx;

  function automatic logic [PW-1:0] reset_pos(input int unsigned i);
    logic [COORD_W-1:0] rx, ry;
    rx = COORD_W'(12);
    ry = COORD_W'(5 + 2 * i);
    return {rx, ry};
  endfunction

  assign body_arr  = body;
  assign apple_pos = pos_q;
  assign busy      = (state_q != StIdle);
  assign len_c     = (body_len > LEN_W'(MAX_LENGTH)) ? LEN_W'(MAX_LENGTH) : body_len;
  assign eat_evt   = sync_q[1] & ~sync_q[2];

  // Descending loop leaves the lowest matching index in match_idx.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = int'(NUM_APPLES) - 1; i >= 0; i--) begin
      if (apple_valid[i] && pos_q[i] == {head_x, head_y}) begin
        match     = 1'b1;
        match_idx = TGT_W'(i);
      end
    end
  end

  always_comb begin
    apple_at   = 1'b0;
    cand_apple = 1'b0;
    for (int i = 0; i < int'(NUM_APPLES); i++) begin
      if (apple_valid[i] && pos_q[i] == {x, y}) apple_at = 1'b1;
      if (apple_valid[i] && pos_q[i] == cand_q) cand_apple = 1'b1;
    end
  end

  // The target apple is invalid while respawning, so it never blocks its own candidate.
  assign body_hit = (idx_q < len_c) && (body_arr[idx_q[IDX_W-1:0]] == cand_q);
  assign hit      = body_hit || cand_apple;
  assign last_idx = (len_c == '0) || (idx_q >= len_c - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      pending_q   <= 1'b0;
      tries_q     <= '0;
      sweep_q     <= '0;
      idx_q       <= '0;
      cand_q      <= '0;
      target_q    <= '0;
      apple_valid <= '1;
      apple       <= 1'b0;
      board_full  <= 1'b0;
      for (int i = 0; i < int'(NUM_APPLES); i++) pos_q[i] <= reset_pos(i);
    end else begin
      sync_q <= {sync_q[1:0], goodColl};
      apple  <= apple_at;
      unique case (state_q)
        StIdle: begin
          pending_q <= 1'b0;
          if ((eat_evt || pending_q) && match) begin
            target_q               <= match_idx;
            apple_valid[match_idx] <= 1'b0;
            state_q                <= StDraw;
          end
        end
        StDraw: begin
          idx_q <= '0;
          if (tries_q >= TRY_W'(MAX_TRIES)) begin
            if (sweep_q == SweepAll) begin
              board_full <= 1'b1;
              state_q    <= StFull;
            end else begin
              cand_q  <= cand_q + PW'(1);
              sweep_q <= sweep_q + SWP_W'(1);
              state_q <= StScan;
            end
          end else begin
            cand_q  <= {rand_x, rand_y};
            state_q <= StScan;
          end
        end
        StScan: begin
          if (hit) begin
            if (tries_q < TRY_W'(MAX_TRIES)) tries_q <= tries_q + TRY_W'(1);
            state_q <= StDraw;
          end else if (last_idx) begin
            state_q <= StCommit;
          end else begin
            idx_q <= idx_q + LEN_W'(1);
          end
        end
        StCommit: begin
          pos_q[target_q]       <= cand_q;
          apple_valid[target_q] <= 1'b1;
          tries_q               <= '0;
          sweep_q               <= '0;
          state_q               <= StIdle;
        end
        StFull: ;
        default: state_q <= StIdle;
      endcase
      if (eat_evt && state_q != StIdle && state_q != StFull) pending_q <= 1'b1;
    end
  end

endmodule
